// File: rtl/ixc_sfifo_chan_arb_pkg.sv
// Shared types, default widths and round-robin helper for the sfifo channel arbiter.
package ixc_sfifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int unsigned DW_DEF = 512;
    localparam int unsigned TW_DEF = 22;
    localparam int unsigned LW_DEF = 4;

    // Next round-robin start position after port ptr, wrapping at nport.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nport);
        return ((ptr + 1) >= nport) ? 32'd0 : (ptr + 1);
    endfunction

endpackage

// File: rtl/ixc_sfifo_chan_arb_if.sv
// Port-array / channel bundle between the sfifo ports, the arbiter and xc_top.
interface ixc_sfifo_chan_arb_if
    import ixc_sfifo_arb_pkg::*;
#(
    parameter int unsigned NPORT = 4,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TW    = TW_DEF,
    parameter int unsigned LW    = LW_DEF
);
    logic [NPORT-1:0]    req_vld;
    logic [NPORT*LW-1:0] req_len;
    logic [NPORT*DW-1:0] req_data;
    logic [NPORT-1:0]    req_rdy;
    logic [NPORT*TW-1:0] port_tid;
    logic [DW-1:0]       CoData;
    logic                CoDataEn;
    logic [LW-1:0]       CoDataLen;
    logic                CoDataRdy;
    logic                CiVld;
    logic [TW-1:0]       CtId;
    logic [NPORT-1:0]    pend;
    logic [NPORT-1:0]    rsp_vld;
    logic                err_unm;

    // Port array and channel side.
    modport master (
        output req_vld, req_len, req_data, port_tid, CoDataRdy, CiVld, CtId,
        input  req_rdy, CoData, CoDataEn, CoDataLen, pend, rsp_vld, err_unm
    );

    // Arbiter side.
    modport slave (
        input  req_vld, req_len, req_data, port_tid, CoDataRdy, CiVld, CtId,
        output req_rdy, CoData, CoDataEn, CoDataLen, pend, rsp_vld, err_unm
    );
endinterface

// File: rtl/ixc_sfifo_chan_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module ixc_rr_pick #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NPORT-1:0] gnt_oh,
    output logic [PW-1:0]    gnt_idx,
    output logic             gnt_vld
);
    int unsigned j;

    // Scan NPORT positions starting at ptr; first hit wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            j = 32'(ptr) + i;
            if (j >= NPORT) j = j - NPORT;
            if (!gnt_vld && req[PW'(j)]) begin
                gnt_vld          = 1'b1;
                gnt_oh[PW'(j)]   = 1'b1;
                gnt_idx          = PW'(j);
            end
        end
    end
endmodule

// File: rtl/ixc_sfifo_chan_arb.sv
// Round-robin arbiter sharing the CoData channel among sfifo ports, with per-port call tracking.
module ixc_sfifo_chan_arb
    import ixc_sfifo_arb_pkg::*;
#(
    parameter int unsigned NPORT = 4,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TW    = TW_DEF,
    parameter int unsigned LW    = LW_DEF
) (
    input  logic                fclk,
    input  logic                GFReset,
    ixc_sfifo_chan_arb_if.slave bus
);
    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_e           state, state_nxt;
    logic [PW-1:0]    rr_ptr, gnt, pick_idx;
    logic [NPORT-1:0] gnt_oh, pick_oh, elig, hit, pend, rsp_vld;
    logic             pick_vld, err_unm, co_en, xfer, last;
    logic [LW-1:0]    len, cnt, pick_len;
    logic [DW-1:0]    co_data;

    assign elig = bus.req_vld & ~pend;

    ixc_rr_pick #(.NPORT(NPORT), .PW(PW)) u_pick (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // Length of the port being picked; a zero length still moves one beat.
    always_comb begin
        pick_len = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (pick_idx == PW'(p)) pick_len = bus.req_len[p*LW +: LW];
        end
        if (pick_len == '0) pick_len = LW'(1);
    end

    // Outbound data mux follows the held grant.
    always_comb begin
        co_data = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (gnt == PW'(p)) co_data = bus.req_data[p*DW +: DW];
        end
    end

    // Reply tid match against pending ports only.
    always_comb begin
        hit = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            hit[p] = bus.CiVld && (bus.CtId == bus.port_tid[p*TW +: TW]) && pend[p];
        end
    end

    // Next-state and beat handshake.
    always_comb begin
        state_nxt = state;
        co_en     = 1'b0;
        xfer      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) state_nxt = STREAM;
            end
            STREAM: begin
                co_en = |(bus.req_vld & gnt_oh);
                xfer  = co_en & bus.CoDataRdy;
                last  = xfer && (cnt == LW'(1));
                if (last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.CoData    = co_data;
    assign bus.CoDataEn  = co_en;
    assign bus.CoDataLen = len;
    assign bus.req_rdy   = xfer ? gnt_oh : '0;
    assign bus.pend      = pend;
    assign bus.rsp_vld   = rsp_vld;
    assign bus.err_unm   = err_unm;

    // State register.
    always_ff @(posedge fclk or posedge GFReset) begin
        if (GFReset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Grant, length, beat counter and round-robin pointer.
    always_ff @(posedge fclk or posedge GFReset) begin
        if (GFReset) begin
            gnt    <= '0;
            gnt_oh <= '0;
            len    <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                gnt    <= pick_idx;
                gnt_oh <= pick_oh;
                len    <= pick_len;
                cnt    <= pick_len;
            end
            if (xfer) cnt <= cnt - LW'(1);
            if (last) rr_ptr <= PW'(rr_next(32'(gnt), NPORT));
        end
    end

    // Outstanding-call tracking; clears see pre-edge pend so a fresh call cannot be retired.
    always_ff @(posedge fclk or posedge GFReset) begin
        if (GFReset) begin
            pend    <= '0;
            rsp_vld <= '0;
            err_unm <= 1'b0;
        end else begin
            pend    <= (pend & ~hit) | (last ? gnt_oh : '0);
            rsp_vld <= hit;
            if (bus.CiVld && (hit == '0)) err_unm <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ixc_sfifo_chan_arb.sv
// Directed self-checking bench for ixc_sfifo_chan_arb.
module tb_ixc_sfifo_chan_arb;
    localparam int unsigned NPORT = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned TW    = 22;
    localparam int unsigned LW    = 4;

    logic fclk = 1'b0;
    logic GFReset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   pops;

    always #5 fclk = ~fclk;

    ixc_sfifo_chan_arb_if #(.NPORT(NPORT), .DW(DW), .TW(TW), .LW(LW)) bus ();

    ixc_sfifo_chan_arb #(.NPORT(NPORT), .DW(DW), .TW(TW), .LW(LW)) dut (
        .fclk    (fclk),
        .GFReset (GFReset),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int p, input int b);
        return {8'hA0, 8'(p), 16'(b)};
    endfunction

    function automatic logic [TW-1:0] tid(input int p);
        return TW'(22'h100 + p);
    endfunction

    function automatic logic [63:0] oh(input int p);
        return 64'(1) << p;
    endfunction

    task automatic set_beat(input int p, input int b);
        bus.req_data[p*DW +: DW] = beat(p, b);
    endtask

    task automatic set_req(input int p, input logic v, input int len, input int b);
        bus.req_vld[p]           = v;
        bus.req_len[p*LW +: LW]  = LW'(len);
        set_beat(p, b);
    endtask

    task automatic do_reset();
        GFReset       = 1'b1;
        bus.req_vld   = '0;
        bus.CiVld     = 1'b0;
        bus.CtId      = '0;
        bus.CoDataRdy = 1'b1;
        tick();
        tick();
        GFReset = 1'b0;
    endtask

    initial begin
        GFReset       = 1'b1;
        bus.req_vld   = '0;
        bus.req_len   = '0;
        bus.req_data  = '0;
        bus.CoDataRdy = 1'b1;
        bus.CiVld     = 1'b0;
        bus.CtId      = '0;
        for (int p = 0; p < NPORT; p++) bus.port_tid[p*TW +: TW] = tid(p);
        tick();
        tick();
        chk("rst_en",   64'(bus.CoDataEn),  0);
        chk("rst_rdy",  64'(bus.req_rdy),   0);
        chk("rst_len",  64'(bus.CoDataLen), 0);
        chk("rst_pend", 64'(bus.pend),      0);
        chk("rst_rsp",  64'(bus.rsp_vld),   0);
        chk("rst_err",  64'(bus.err_unm),   0);
        GFReset = 1'b0;

        // 1: single port 0, three beats, then reply retires the call
        set_req(0, 1'b1, 3, 0);
        #1;
        chk("t1_idle_en", 64'(bus.CoDataEn), 0);
        for (int b = 0; b < 3; b++) begin
            tick();
            chk("t1_en",   64'(bus.CoDataEn),  1);
            chk("t1_len",  64'(bus.CoDataLen), 3);
            chk("t1_rdy",  64'(bus.req_rdy),   oh(0));
            chk("t1_data", 64'(bus.CoData),    64'(beat(0, b)));
            set_beat(0, b + 1);
        end
        tick();
        bus.req_vld[0] = 1'b0;
        #1;
        chk("t1_pend_set", 64'(bus.pend),     oh(0));
        chk("t1_en_off",   64'(bus.CoDataEn), 0);
        bus.CiVld = 1'b1;
        bus.CtId  = tid(0);
        tick();
        bus.CiVld = 1'b0;
        #1;
        chk("t1_rsp",     64'(bus.rsp_vld), oh(0));
        chk("t1_pend_clr", 64'(bus.pend),   0);
        tick();
        chk("t1_rsp_end", 64'(bus.rsp_vld), 0);
        chk("t1_err",     64'(bus.err_unm), 0);

        // 2: all ports len=1, immediate replies, order 0,1,2,3,0
        do_reset();
        for (int p = 0; p < NPORT; p++) set_req(p, 1'b1, 1, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_rdy",  64'(bus.req_rdy), oh(k % 4));
            chk("t2_data", 64'(bus.CoData),  64'(beat(k % 4, 0)));
            tick();
            chk("t2_pend", 64'(bus.pend), oh(k % 4));
            bus.CiVld = 1'b1;
            bus.CtId  = tid(k % 4);
            tick();
            bus.CiVld = 1'b0;
            #1;
            chk("t2_rsp", 64'(bus.rsp_vld), oh(k % 4));
        end
        chk("t2_err", 64'(bus.err_unm), 0);

        // 3: port 1 len=4 with a 3-cycle stall on beat 2
        do_reset();
        set_req(1, 1'b1, 4, 0);
        pops = 0;
        tick();
        #1;
        chk("t3_b0",  64'(bus.CoData),    64'(beat(1, 0)));
        chk("t3_len", 64'(bus.CoDataLen), 4);
        pops += int'(bus.req_rdy[1]);
        tick();
        set_beat(1, 1);
        #1;
        chk("t3_b1", 64'(bus.CoData), 64'(beat(1, 1)));
        pops += int'(bus.req_rdy[1]);
        tick();
        set_beat(1, 2);
        bus.CoDataRdy = 1'b0;
        repeat (3) begin
            #1;
            chk("t3_stall_data", 64'(bus.CoData),   64'(beat(1, 2)));
            chk("t3_stall_rdy",  64'(bus.req_rdy),  0);
            chk("t3_stall_en",   64'(bus.CoDataEn), 1);
            tick();
        end
        bus.CoDataRdy = 1'b1;
        #1;
        chk("t3_b2", 64'(bus.CoData), 64'(beat(1, 2)));
        pops += int'(bus.req_rdy[1]);
        tick();
        set_beat(1, 3);
        #1;
        chk("t3_b3", 64'(bus.CoData), 64'(beat(1, 3)));
        pops += int'(bus.req_rdy[1]);
        tick();
        chk("t3_pops", 64'(pops),         4);
        chk("t3_pend", 64'(bus.pend),     oh(1));
        chk("t3_done", 64'(bus.CoDataEn), 0);

        // 4: port 2 pending keeps requesting; ports 3 and 0 still served
        do_reset();
        set_req(2, 1'b1, 1, 0);
        tick();
        #1;
        chk("t4_rdy2", 64'(bus.req_rdy), oh(2));
        tick();
        set_req(0, 1'b1, 1, 0);
        set_req(3, 1'b1, 1, 0);
        chk("t4_pend2", 64'(bus.pend), oh(2));
        tick();
        #1;
        chk("t4_rdy3", 64'(bus.req_rdy), oh(3));
        tick();
        chk("t4_pend23", 64'(bus.pend), 64'h0C);
        tick();
        #1;
        chk("t4_rdy0", 64'(bus.req_rdy), oh(0));
        tick();
        repeat (3) begin
            #1;
            chk("t4_idle_en",  64'(bus.CoDataEn), 0);
            chk("t4_idle_rdy", 64'(bus.req_rdy),  0);
            tick();
        end
        chk("t4_pend", 64'(bus.pend), 64'h0D);

        // 5: unmatched reply sets the sticky error only
        bus.CiVld = 1'b1;
        bus.CtId  = tid(1);
        tick();
        bus.CiVld = 1'b0;
        #1;
        chk("t5_err",  64'(bus.err_unm), 1);
        chk("t5_rsp",  64'(bus.rsp_vld), 0);
        chk("t5_pend", 64'(bus.pend),    64'h0D);
        tick();
        tick();
        chk("t5_sticky", 64'(bus.err_unm), 1);

        // 6: reset mid-packet abandons it; first grant afterwards is port 0
        do_reset();
        #1;
        chk("t6_err_clr", 64'(bus.err_unm), 0);
        set_req(1, 1'b1, 1, 0);
        tick();
        tick();
        bus.req_vld[1] = 1'b0;
        set_req(2, 1'b1, 3, 0);
        chk("t6_pend1", 64'(bus.pend), oh(1));
        tick();
        #1;
        chk("t6_rdy2", 64'(bus.req_rdy), oh(2));
        tick();
        set_beat(2, 1);
        #1;
        chk("t6_mid_en", 64'(bus.CoDataEn), 1);
        GFReset = 1'b1;
        #1;
        chk("t6_rst_en",   64'(bus.CoDataEn),  0);
        chk("t6_rst_pend", 64'(bus.pend),      0);
        chk("t6_rst_rdy",  64'(bus.req_rdy),   0);
        chk("t6_rst_len",  64'(bus.CoDataLen), 0);
        set_req(0, 1'b1, 1, 0);
        tick();
        GFReset = 1'b0;
        tick();
        #1;
        chk("t6_first_gnt", 64'(bus.req_rdy), oh(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
